nand_gate: RTL and testbench

- Parameterised multi-input bitwise NAND with a registered output and a combinational output.
- Up to 8 input buses (a..h). PORT_NUM selects how many participate.
- Used as a library logic primitive wherever a clean, clocked NAND of several operands is needed.

---
 rtl/nand_gate.sv | 62 ++++++
 tb/tb_nand_gate.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/nand_gate.sv
// Parameterised multi-input bitwise NAND primitive with a combinational
// result and a registered copy. Inputs a..h are taken in order; only the
// first PORT_NUM participate, the rest are ignored as if all-ones.
module nand_gate #(
    parameter int PORT_NUM = 8,
    parameter int WIDTH    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] e,
    input  logic [WIDTH-1:0] f,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] h,
    output logic [WIDTH-1:0] q_comb,
    output logic [WIDTH-1:0] q
);

    localparam int unsigned MAX_PORTS = 8;

    // Reject out-of-range parameters at elaboration time.
    if (PORT_NUM < 2 || PORT_NUM > 8 || WIDTH < 1) begin : g_bad_param
        $fatal(1, "nand_gate: illegal parameters PORT_NUM=%0d WIDTH=%0d (PORT_NUM 2..8, WIDTH >= 1)",
               PORT_NUM, WIDTH);
    end

    logic [WIDTH-1:0] ops [MAX_PORTS];
    logic [WIDTH-1:0] and_all;

    assign ops[0] = a;
    assign ops[1] = b;
    assign ops[2] = c;
    assign ops[3] = d;
    assign ops[4] = e;
    assign ops[5] = f;
    assign ops[6] = g;
    assign ops[7] = h;

    // Bitwise AND of the active operands; inactive ones never enter the product.
    always_comb begin
        and_all = '1;
        for (int i = 0; i < int'(MAX_PORTS); i++) begin
            if (i < PORT_NUM) begin
                and_all = and_all & ops[i];
            end
        end
        q_comb = ~and_all;
    end

    // Registered copy of the NAND; reset forces all-ones immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '1;
        end else begin
            q <= q_comb;
        end
    end

endmodule

// File: tb/tb_nand_gate.sv
// Directed self-checking bench for nand_gate across several parameter sets.
module tb_nand_gate;

    logic clk;
    logic rst;

    // PORT_NUM=8, WIDTH=1
    logic [7:0] in8;
    logic       q8_comb, q8;
    // PORT_NUM=2, WIDTH=1
    logic [7:0] in2;
    logic       q2_comb, q2;
    // PORT_NUM=8, WIDTH=4
    logic [3:0] w4 [8];
    logic [3:0] q4_comb, q4;
    // PORT_NUM=5, WIDTH=3
    logic [2:0] v5 [8];
    logic [2:0] q5_comb, q5;

    int n_checks;
    int n_fail;

    nand_gate #(.PORT_NUM(8), .WIDTH(1)) u_p8w1 (
        .clk(clk), .rst(rst),
        .a(in8[0]), .b(in8[1]), .c(in8[2]), .d(in8[3]),
        .e(in8[4]), .f(in8[5]), .g(in8[6]), .h(in8[7]),
        .q_comb(q8_comb), .q(q8)
    );

    nand_gate #(.PORT_NUM(2), .WIDTH(1)) u_p2w1 (
        .clk(clk), .rst(rst),
        .a(in2[0]), .b(in2[1]), .c(in2[2]), .d(in2[3]),
        .e(in2[4]), .f(in2[5]), .g(in2[6]), .h(in2[7]),
        .q_comb(q2_comb), .q(q2)
    );

    nand_gate #(.PORT_NUM(8), .WIDTH(4)) u_p8w4 (
        .clk(clk), .rst(rst),
        .a(w4[0]), .b(w4[1]), .c(w4[2]), .d(w4[3]),
        .e(w4[4]), .f(w4[5]), .g(w4[6]), .h(w4[7]),
        .q_comb(q4_comb), .q(q4)
    );

    nand_gate #(.PORT_NUM(5), .WIDTH(3)) u_p5w3 (
        .clk(clk), .rst(rst),
        .a(v5[0]), .b(v5[1]), .c(v5[2]), .d(v5[3]),
        .e(v5[4]), .f(v5[5]), .g(v5[6]), .h(v5[7]),
        .q_comb(q5_comb), .q(q5)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Wait for the next rising edge and step just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] ab_vec [4];
    logic       ab_exp [4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ab_vec = '{2'b00, 2'b10, 2'b01, 2'b11};   // {b,a}: (a,b)=(0,0),(0,1),(1,0),(1,1)
        ab_exp = '{1'b1, 1'b1, 1'b1, 1'b0};

        rst = 1'b1;
        in8 = 8'hFF;
        in2 = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w4[i] = 4'hF;
            v5[i] = 3'h7;
        end
        #1;
        // Reset state: all registered outputs all-ones.
        check("rst_q8", 32'(q8), 32'h1);
        check("rst_q2", 32'(q2), 32'h1);
        check("rst_q4", 32'(q4), 32'hF);
        check("rst_q5", 32'(q5), 32'h7);
        // q_comb ignores reset: all-ones inputs give 0 even in reset.
        check("rst_qc8", 32'(q8_comb), 32'h0);
        tick();
        check("rst_hold_q8", 32'(q8), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rel_q8", 32'(q8), 32'h0);

        // Two-input truth table on the 8-port instance, c..h held high.
        for (int k = 0; k < 4; k++) begin
            in8[1:0] = ab_vec[k];
            #1;
            check($sformatf("tt_comb_%0d", k), 32'(q8_comb), 32'(ab_exp[k]));
            tick();
            check($sformatf("tt_q_%0d", k), 32'(q8), 32'(ab_exp[k]));
            repeat (9) @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-cycle with a=b=1 (q currently 0).
        check("pre_rst_q8", 32'(q8), 32'h0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_q8", 32'(q8), 32'h1);
        check("async_rst_qc8", 32'(q8_comb), 32'h0);
        tick();
        check("rst_held_q8", 32'(q8), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_fall_no_edge_q8", 32'(q8), 32'h1);
        tick();
        check("rst_fall_edge_q8", 32'(q8), 32'h0);

        // PORT_NUM=2: a=b=1, inactive c..h=0 must be ignored.
        in2 = 8'b0000_0011;
        #1;
        check("p2_comb", 32'(q2_comb), 32'h0);
        tick();
        check("p2_q", 32'(q2), 32'h0);
        in2 = 8'b1111_1101;
        #1;
        check("p2_b0_comb", 32'(q2_comb), 32'h1);

        // WIDTH=4: per-bit independence.
        w4[0] = 4'b1010;
        w4[1] = 4'b1100;
        #1;
        check("w4_comb", 32'(q4_comb), 32'h7);
        tick();
        check("w4_q", 32'(q4), 32'h7);
        w4[0] = 4'hF;
        w4[1] = 4'hF;
        #1;
        check("w4_ones_comb", 32'(q4_comb), 32'h0);
        check("w4_ones_q_old", 32'(q4), 32'h7);
        tick();
        check("w4_ones_q", 32'(q4), 32'h0);
        w4[5] = 4'b1011;
        #1;
        check("w4_f_comb", 32'(q4_comb), 32'h4);

        // Last input h participates.
        in8 = 8'h7F;
        #1;
        check("h0_comb", 32'(q8_comb), 32'h1);
        in8 = 8'hFF;
        #1;
        check("h1_comb", 32'(q8_comb), 32'h0);
        in8 = 8'h7F;
        #1;
        check("h0b_comb", 32'(q8_comb), 32'h1);
        tick();
        check("h0b_q", 32'(q8), 32'h1);

        // PORT_NUM=5: e participates, f..h do not.
        v5[5] = 3'b000;
        v5[6] = 3'b000;
        v5[7] = 3'b010;
        #1;
        check("p5_inact_comb", 32'(q5_comb), 32'h0);
        v5[4] = 3'b101;
        #1;
        check("p5_e_comb", 32'(q5_comb), 32'h2);
        v5[0] = 3'b110;
        #1;
        check("p5_ae_comb", 32'(q5_comb), 32'h3);
        tick();
        check("p5_q", 32'(q5), 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
